// File: rtl/coeff_token_enc_neg1.sv
// coeff_token_enc_neg1: bit-serial CAVLC coeff_token encoder for nC = -1 (chroma DC)
module coeff_token_enc_neg1 (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        InValid,
  output logic        InReady,
  input  logic [4:0]  TotalCoeff,
  input  logic [1:0]  TrailingOnes,
  output logic        BitValid,
  input  logic        BitReady,
  output logic        Bit,
  output logic        BitLast,
  output logic        Error,
  output logic [15:0] BitCount
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [7:0] sr;
  logic [3:0] cnt;
  logic [7:0] code;
  logic [3:0] len;
  logic legal, accept, load, step;
  // Codeword lookup, left-aligned in 8 bits so the MSB leaves first
  always_comb begin
    code = 8'b0000_0000;
    len = 4'd0;
    case ({TotalCoeff, TrailingOnes})
      {5'd0, 2'd0}: begin code = 8'b0100_0000; len = 4'd2; end
      {5'd1, 2'd0}: begin code = 8'b0001_1100; len = 4'd6; end
      {5'd1, 2'd1}: begin code = 8'b1000_0000; len = 4'd1; end
      {5'd2, 2'd0}: begin code = 8'b0001_0000; len = 4'd6; end
      {5'd2, 2'd1}: begin code = 8'b0001_1000; len = 4'd6; end
      {5'd2, 2'd2}: begin code = 8'b0010_0000; len = 4'd3; end
      {5'd3, 2'd0}: begin code = 8'b0000_1100; len = 4'd6; end
      {5'd3, 2'd1}: begin code = 8'b0000_0110; len = 4'd7; end
      {5'd3, 2'd2}: begin code = 8'b0000_0100; len = 4'd7; end
      {5'd3, 2'd3}: begin code = 8'b0001_0100; len = 4'd6; end
      {5'd4, 2'd0}: begin code = 8'b0000_1000; len = 4'd6; end
      {5'd4, 2'd1}: begin code = 8'b0000_0011; len = 4'd8; end
      {5'd4, 2'd2}: begin code = 8'b0000_0010; len = 4'd8; end
      {5'd4, 2'd3}: begin code = 8'b0000_0000; len = 4'd7; end
      default: begin code = 8'b0000_0000; len = 4'd0; end
    endcase
  end
  // Handshakes and next state; a symbol may be taken on the final bit of the previous one
  always_comb begin
    legal = TotalCoeff <= 5'd4 && {3'b000, TrailingOnes} <= TotalCoeff;
    BitValid = state == SHIFT;
    BitLast = BitValid && cnt == 4'd1;
    step = BitValid && BitReady;
    InReady = !Rst && (state == IDLE || (BitLast && BitReady));
    accept = InValid && InReady;
    load = accept && legal;
    state_nx = load ? SHIFT : (BitValid && !(BitLast && BitReady)) ? SHIFT : IDLE;
  end
  // State register
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) state <= IDLE;
    else state <= state_nx;
  // Shift register, remaining length, error pulse and emitted-bit counter
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      sr <= 8'd0;
      cnt <= 4'd0;
      Error <= 1'b0;
      BitCount <= 16'd0;
    end else begin
      Error <= accept && !legal;
      if (load) begin
        sr <= code;
        cnt <= len;
      end else if (step) begin
        sr <= sr << 1;
        cnt <= cnt - 4'd1;
      end
      if (step) BitCount <= BitCount + 16'd1;
    end
  assign Bit = sr[7];
endmodule

// File: tb/tb_coeff_token_enc_neg1.sv
// tb_coeff_token_enc_neg1: directed stimulus checked against a bit-queue model of the codeword table
module tb_coeff_token_enc_neg1;
  logic Clk = 0, Rst = 1, InValid = 0, BitReady = 1;
  logic [4:0] TotalCoeff = 0;
  logic [1:0] TrailingOnes = 0;
  logic InReady, BitValid, Bit, BitLast, Error;
  logic [15:0] BitCount;
  int n_chk = 0, n_fail = 0;
  bit q[$];
  logic [15:0] bc = 0;
  bit err_exp = 0;
  bit ev, el, er;
  string s;

  coeff_token_enc_neg1 dut (
    .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
    .TotalCoeff(TotalCoeff), .TrailingOnes(TrailingOnes),
    .BitValid(BitValid), .BitReady(BitReady), .Bit(Bit), .BitLast(BitLast),
    .Error(Error), .BitCount(BitCount)
  );

  always #5 Clk = ~Clk;

  function automatic string cw(input int tc, input int t1);
    case (tc * 4 + t1)
      0: return "01";
      4: return "000111";
      5: return "1";
      8: return "000100";
      9: return "000110";
      10: return "001";
      12: return "000011";
      13: return "0000011";
      14: return "0000010";
      15: return "000101";
      16: return "000010";
      17: return "00000011";
      18: return "00000010";
      19: return "0000000";
      default: return "";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: a queue of codeword bits still owed; checked every cycle, then advanced for the coming edge
  always @(negedge Clk) begin
    if (Rst) begin
      q.delete();
      bc = 0;
      err_exp = 0;
      chk("rst_inready", InReady, 0);
      chk("rst_bitvalid", BitValid, 0);
      chk("rst_bit", Bit, 0);
      chk("rst_bitlast", BitLast, 0);
      chk("rst_error", Error, 0);
      chk("rst_bitcount", BitCount, 0);
    end else begin
      ev = q.size() > 0;
      el = q.size() == 1;
      er = !ev || (el && BitReady);
      chk("bitvalid", BitValid, ev);
      chk("bitlast", BitLast, el);
      chk("inready", InReady, er);
      chk("error", Error, err_exp);
      chk("bitcount", BitCount, bc);
      if (ev) chk("bit", Bit, q[0]);
      err_exp = 0;
      if (ev && BitReady) begin
        void'(q.pop_front());
        bc = bc + 16'd1;
      end
      if (InValid && er) begin
        s = cw(int'(TotalCoeff), int'(TrailingOnes));
        if (s.len() == 0) err_exp = 1;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i] == "1");
      end
    end
  end

  task automatic send(input int tc, input int t1);
    bit acc = 0;
    TotalCoeff = tc[4:0];
    TrailingOnes = t1[1:0];
    InValid = 1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge Clk);
      acc = InReady;
      @(posedge Clk);
      #1;
    end
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: symbol (%0d,%0d) not accepted in 20 cycles", tc, t1);
    end
  endtask

  task automatic drain(input bit tog);
    int k = 0;
    InValid = 0;
    while (q.size() != 0 && k < 200) begin
      if (tog) BitReady = ~BitReady;
      @(posedge Clk);
      #1;
      k++;
    end
    BitReady = 1;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d bits still owed after 200 cycles", q.size());
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk("lit_inready_in_rst", InReady, 0);
    Rst = 0;
    #1;
    chk("lit_inready_idle", InReady, 1);
    @(posedge Clk);
    #1;
    send(1, 1);
    InValid = 0;
    @(negedge Clk);
    chk("lit_t1_bit", Bit, 1);
    chk("lit_t1_last", BitLast, 1);
    @(posedge Clk);
    #1;
    drain(0);
    chk("lit_t1_count", BitCount, 1);
    for (int tc = 0; tc <= 4; tc++)
      for (int t1 = 0; t1 <= (tc < 3 ? tc : 3); t1++) send(tc, t1);
    drain(0);
    chk("lit_all_count", BitCount, 80);
    send(4, 1);
    drain(1);
    chk("lit_stall_count", BitCount, 88);
    send(5, 0);
    send(2, 3);
    InValid = 0;
    @(negedge Clk);
    chk("lit_err_pulse", Error, 1);
    chk("lit_err_novalid", BitValid, 0);
    @(posedge Clk);
    #1;
    send(0, 0);
    drain(0);
    chk("lit_err_count", BitCount, 90);
    send(4, 2);
    InValid = 0;
    repeat (3) @(posedge Clk);
    #1;
    Rst = 1;
    #1;
    chk("lit_abort_valid", BitValid, 0);
    chk("lit_abort_count", BitCount, 0);
    repeat (2) @(posedge Clk);
    #1;
    Rst = 0;
    send(3, 3);
    drain(0);
    chk("lit_after_abort", BitCount, 6);
    Rst = 1;
    @(posedge Clk);
    #1;
    Rst = 0;
    for (int i = 0; i < 8191; i++) send(4, 1);
    send(1, 0);
    drain(0);
    chk("lit_preload", BitCount, 16'hFFFE);
    send(0, 0);
    drain(0);
    chk("lit_wrap", BitCount, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
